// File: rtl/booth_acc_pkg.sv
// Shared types and constants for the Booth product accumulator slice.
// Saturating accumulation is selected at build time with macro BOOTH_ACC_SAT_EN.
package booth_acc_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 20;
    localparam int LEN_W_DEF  = 8;

    // Clamp limits for the default accumulator width.
    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/booth_product_accumulator_addsat.sv
// Combinational signed accumulator + product add with overflow flag.
// With BOOTH_ACC_SAT_EN defined the result clamps on overflow; otherwise it wraps.
module booth_acc_addsat #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] prod_in,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);

    logic [ACC_W:0] acc_ext;
    logic [ACC_W:0] prod_ext;
    logic [ACC_W:0] sum;

    // One guard bit above the accumulator makes the true sign of the sum visible.
    assign acc_ext  = {acc_in[ACC_W-1], acc_in};
    assign prod_ext = {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    assign sum      = acc_ext + prod_ext;
    assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef BOOTH_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        acc_out = sum[ACC_W-1:0];
        if (ovf) begin
            acc_out = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign acc_out = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums a run of LEN signed products into one result with valid/ready on both sides.
// Build option BOOTH_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module booth_product_accumulator
    import booth_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;

    logic              transfer;
    logic [ACC_W-1:0]  add_acc;
    logic              add_ovf;

    booth_acc_addsat #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_addsat (
        .acc_in  (acc_q),
        .prod_in (in_product),
        .acc_out (add_acc),
        .ovf     (add_ovf)
    );

    // in_ready is a pure decode of the registered state, so this has no in_valid -> in_ready path.
    assign transfer = in_valid && (state_q == ACCUM);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            remaining_q <= remaining_d;
        end
    end

    // NOTE: each comb block assigns defaults first so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (transfer && (remaining_q == LEN_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        remaining_d = remaining_q;
        if (state_q == IDLE && start) begin
            acc_d       = '0;
            ovf_d       = 1'b0;
            remaining_d = len;
        end else if (transfer) begin
            acc_d       = add_acc;
            ovf_d       = ovf_q | add_ovf;
            remaining_d = remaining_q - LEN_W'(1);
        end
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_acc   = (state_q == DONE) ? acc_q : '0;
        out_ovf   = (state_q == DONE) ? ovf_q : 1'b0;
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Randomised scoreboard bench for booth_product_accumulator; honours BOOTH_ACC_SAT_EN.
module tb_booth_product_accumulator;

    localparam int PW = 16;
    localparam int AW = 20;
    localparam int LW = 8;
    localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) << (AW - 1));
    localparam longint SPAN = longint'(1) << AW;
    localparam int GUARD = 200;

    typedef struct packed {
        logic [AW-1:0] acc;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_product;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          out_ovf;
    logic          busy;

    exp_t exp_q[$];
    int   stim[$];
    bit   vpat[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    booth_product_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum, with range violations either clamped or wrapped.
    function automatic exp_t model_run();
        longint a = 0;
        bit     o = 1'b0;
        exp_t   e;
        foreach (stim[i]) begin
            a += stim[i];
            if (a > AMAX || a < AMIN) begin
                o = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
                a = (a > AMAX) ? AMAX : AMIN;
`else
                a = (a > AMAX) ? a - SPAN : a + SPAN;
`endif
            end
        end
        e.acc = AW'(a);
        e.ovf = o;
        return e;
    endfunction

    // Monitor: compares each handshaked result against the scoreboard queue.
    logic          held = 1'b0;
    logic [AW-1:0] held_acc;
    logic          held_ovf;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            held = 1'b0;
        end else if (out_valid === 1'b1) begin
            check("in_ready_in_done", in_ready, 0);
            if (held) begin
                check("stable_acc", $signed(out_acc), $signed(held_acc));
                check("stable_ovf", out_ovf, held_ovf);
            end
            if (out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_acc", $signed(out_acc), $signed(e.acc));
                    check("result_ovf", out_ovf, e.ovf);
                end
                held = 1'b0;
            end else begin
                held     = 1'b1;
                held_acc = out_acc;
                held_ovf = out_ovf;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_acc"},   out_acc,   0);
        check({tag, "_out_ovf"},   out_ovf,   0);
        check({tag, "_busy"},      busy,      0);
    endtask

    // Runs one job from stim[]; entered and left at posedge+1 with the DUT idle.
    task automatic run_stream(input int gap_pct, input int ready_delay, input bit poke_start);
        int n;
        bit xfer;
        int guard;
        n = stim.size();
        exp_q.push_back(model_run());
        out_ready = (ready_delay == 0);
        start     = 1'b1;
        len       = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            check("len0_out_valid", out_valid, 1);
            check("len0_in_ready", in_ready, 0);
        end
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                if (vpat.size() > 0) in_valid = vpat.pop_front();
                else                 in_valid = ($urandom_range(99) >= gap_pct);
                in_product = PW'(stim[i]);
                if (poke_start && i == n / 2) begin
                    start = 1'b1;
                    len   = LW'($urandom_range(1, 9));
                end
                xfer = in_valid && (in_ready === 1'b1);
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
            end while (!xfer && guard < GUARD);
            if (!xfer) check("xfer_timeout", 0, 1);
        end
        in_valid = 1'b0;
        if (n > 0) check("latency_out_valid", out_valid, 1);
        for (int d = 0; d < ready_delay; d++) begin
            if (poke_start) begin
                start = 1'b1;
                len   = LW'($urandom_range(0, 9));
            end
            @(posedge clk); #1;
            start = 1'b0;
            check("held_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        if (poke_start) begin
            start = 1'b1;
            len   = LW'(3);
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("post_handshake_valid", out_valid, 0);
        check("post_handshake_busy", busy, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        in_valid   = 1'b0;
        in_product = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Consecutive products, consumer always ready.
        stim = '{3, -5, 100, -2};
        run_stream(0, 0, 1'b0);

        // Input gaps and a stalled consumer.
        stim = '{10, 20, -40};
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_stream(0, 5, 1'b0);

        // Overflow past +2^19.
        stim.delete();
        for (int i = 0; i < 32; i++) stim.push_back(16384);
        run_stream(0, 0, 1'b0);

        // Empty run.
        stim.delete();
        run_stream(0, 2, 1'b0);

        // Reset in the middle of a run.
        start = 1'b1;
        len   = LW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid   = 1'b1;
            in_product = PW'($urandom_range(0, 65535));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all_zero("midrun_reset");
        stim = '{-7};
        run_stream(0, 0, 1'b0);

        // Stray start pulses during ACCUM, DONE and the handshake cycle.
        stim = '{1000, -3000, 77, 12, -1};
        run_stream(20, 3, 1'b1);

        // Randomised runs, some with large products to provoke overflow.
        for (int r = 0; r < 30; r++) begin
            int n;
            bit big;
            n   = $urandom_range(0, 40);
            big = ($urandom_range(3) == 0);
            stim.delete();
            for (int i = 0; i < n; i++) begin
                if (big) stim.push_back(($urandom_range(1) != 0) ? 32767 - $urandom_range(2000)
                                                                : -32768 + $urandom_range(2000));
                else     stim.push_back($urandom_range(0, 65535) - 32768);
            end
            run_stream($urandom_range(0, 40), $urandom_range(0, 3), ($urandom_range(4) == 0));
        end

        begin
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < GUARD) begin
                @(posedge clk);
                guard++;
            end
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
